// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a small word memory, with programmable wait states.
// Define APB_SLV_PSLVERR_EN to flag out-of-range accesses with PSLVERR instead of wrapping the index.
module apb_slave_mem #(
  parameter int          AW          = 9,
  parameter int          DW          = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  logic [DW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic          write_q, write_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          pready_q, pready_d;
  logic          pslverr_q, pslverr_d;
  logic [DW-1:0] prdata_q;

  logic          setup_pulse;
  logic          rd_load, rd_clr, mem_we;
  logic [IW-1:0] rd_idx;
  logic          rd_err, rd_write;

  logic [AW-2:0] raw_idx;
  logic [IW-1:0] cur_idx;
  logic          cur_err;
  logic          unused_msb;

  assign raw_idx    = paddr[AW-2:0];
  assign unused_msb = paddr[AW-1];

`ifdef APB_SLV_PSLVERR_EN
  assign cur_err = (32'(raw_idx) >= DEPTH);
  assign cur_idx = raw_idx[IW-1:0];
`else
  // Wrap modulo DEPTH; collapses to a plain truncation for power-of-two depths.
  assign cur_err = 1'b0;
  assign cur_idx = IW'(32'(raw_idx) % DEPTH);
`endif

  assign setup_pulse = psel && !penable;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    rd_load   = 1'b0;
    rd_clr    = 1'b0;
    mem_we    = 1'b0;
    rd_idx    = idx_q;
    rd_err    = err_q;
    rd_write  = write_q;
    case (state_q)
      IDLE: begin
        if (setup_pulse) begin
          state_d  = ACCESS;
          idx_d    = cur_idx;
          err_d    = cur_err;
          write_d  = pwrite;
          wdata_d  = pwdata;
          cnt_d    = 4'(WAIT_CYCLES);
          pready_d = (WAIT_CYCLES == 0);
          if (WAIT_CYCLES == 0) begin
            rd_load   = 1'b1;
            rd_idx    = cur_idx;
            rd_err    = cur_err;
            rd_write  = pwrite;
            pslverr_d = cur_err;
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d   = IDLE;
          cnt_d     = 4'd0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          rd_clr    = 1'b1;
        end else if (!pready_q) begin
          cnt_d    = cnt_q - 4'd1;
          pready_d = (cnt_q == 4'd1);
          if (cnt_q == 4'd1) begin
            rd_load   = 1'b1;
            pslverr_d = err_q;
          end
        end else if (penable) begin
          mem_we    = write_q && !err_q;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          rd_clr    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // A reset coinciding with the completing edge must drop the write.
  always_ff @(posedge pclk) begin
    if (mem_we && !preset) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset || rd_clr) begin
      prdata_q <= '0;
    end else if (rd_load) begin
      prdata_q <= (rd_err || rd_write) ? '0 : mem[rd_idx];
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: three instances (different wait states / depths) share one APB bus.
// The stimulus pushes expected responses; a negedge monitor pops and compares on every pready.
module tb_apb_slave_mem;

`ifdef APB_SLV_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int         inst;
    bit         chk;
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  logic       pclk = 1'b0;
  logic       preset;
  logic [2:0] psel_v;
  logic       penable, pwrite;
  logic [8:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata_v [3];
  logic [2:0] pready_v, pslverr_v;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   wait_of [3] = '{0, 3, 2};
  exp_t sb [$];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_slave_mem #(.AW(9), .DW(8), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));

  apb_slave_mem #(.AW(9), .DW(8), .DEPTH(256), .WAIT_CYCLES(3)) u_w3 (
    .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));

  apb_slave_mem #(.AW(9), .DW(8), .DEPTH(200), .WAIT_CYCLES(2)) u_d200 (
    .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pready must match the oldest expected response, including its cycle.
  always @(negedge pclk) begin
    if (!preset) begin
      for (int i = 0; i < 3; i++) begin
        if (pready_v[i]) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL spurious_pready: inst%0d pready=1 at cyc %0d, expected none", i, cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            $display("txn inst=%0d data=%h err=%0d cyc=%0d", i, prdata_v[i], pslverr_v[i], cyc);
            if (e.inst != i || e.cyc != cyc || pslverr_v[i] !== e.err ||
                (e.chk && prdata_v[i] !== e.data)) begin
              bad++;
              $display("FAIL rsp: got inst%0d data=%h err=%0d cyc=%0d, expected inst%0d data=%h err=%0d cyc=%0d",
                       i, prdata_v[i], pslverr_v[i], cyc, e.inst, e.data, e.err, e.cyc);
            end
          end
        end
      end
    end
  end

  // Entered just after a posedge; returns just after the completing posedge with the bus idle.
  task automatic xfer(input int inst, input bit wr, input logic [8:0] addr, input logic [7:0] wd,
                      input logic [7:0] rd_exp, input bit err_exp);
    exp_t e;
    bit   seen;
    psel_v  = 3'b001 << inst;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    @(posedge pclk); #1;
    e.inst = inst; e.chk = !wr; e.data = rd_exp; e.err = err_exp; e.cyc = cyc + wait_of[inst];
    sb.push_back(e);
    penable = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge pclk);
      seen = pready_v[inst];
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: inst%0d addr %h got no pready, expected pready", inst, addr);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    @(posedge pclk); #1;
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    int  c0;
    bit  hi;
    preset  = 1'b1;
    psel_v  = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_state_inst%0d", i), {22'd0, prdata_v[i], pready_v[i], pslverr_v[i]}, 32'd0);
    end
    @(posedge pclk); #1;

    // Zero wait states; the address MSB is not decoded.
    xfer(0, 1, 9'h003, 8'hA5, 8'h00, 1'b0);
    xfer(0, 0, 9'h003, 8'h00, 8'hA5, 1'b0);
    xfer(0, 0, 9'h103, 8'h00, 8'hA5, 1'b0);

    // Three wait states.
    xfer(1, 1, 9'h010, 8'h3C, 8'h00, 1'b0);
    xfer(1, 0, 9'h010, 8'h00, 8'h3C, 1'b0);

    // Back-to-back: six transfers, two cycles each.
    c0 = cyc;
    xfer(0, 1, 9'h000, 8'h11, 8'h00, 1'b0);
    xfer(0, 1, 9'h001, 8'h22, 8'h00, 1'b0);
    xfer(0, 1, 9'h002, 8'h33, 8'h00, 1'b0);
    xfer(0, 0, 9'h000, 8'h00, 8'h11, 1'b0);
    xfer(0, 0, 9'h001, 8'h00, 8'h22, 1'b0);
    xfer(0, 0, 9'h002, 8'h00, 8'h33, 1'b0);
    check("b2b_cycles", cyc - c0, 32'd12);

    // DEPTH=200: 0xF0 is out of range (error) or wraps to 0x28.
    xfer(2, 1, 9'h028, 8'h99, 8'h00, 1'b0);
    xfer(2, 1, 9'h0F0, 8'h5A, 8'h00, ERR_EN);
    xfer(2, 0, 9'h0F0, 8'h00, ERR_EN ? 8'h00 : 8'h5A, ERR_EN);
    xfer(2, 0, 9'h028, 8'h00, ERR_EN ? 8'h99 : 8'h5A, 1'b0);

    // Reset during the wait states of a write drops it.
    xfer(2, 1, 9'h005, 8'h44, 8'h00, 1'b0);
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 9'h005; pwdata = 8'h77;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; psel_v = 3'b000; penable = 1'b0;
    @(negedge pclk);
    check("reset_mid_outputs", {22'd0, prdata_v[2], pready_v[2], pslverr_v[2]}, 32'd0);
    @(posedge pclk); #1;
    xfer(2, 0, 9'h005, 8'h00, 8'h44, 1'b0);

    // Abort: psel drops during wait states; no write, no pready.
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 9'h010; pwdata = 8'h66;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel_v = 3'b000; penable = 1'b0;
    hi = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      hi = hi | pready_v[1];
    end
    check("abort_pready", {31'd0, hi}, 32'd0);
    @(posedge pclk); #1;
    xfer(1, 0, 9'h010, 8'h00, 8'h3C, 1'b0);

    repeat (4) @(posedge pclk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
